a1_scaler_reader: RTL and testbench

Read-side consumer of the A1 scaler divider chain. Samples the ripple-clocked scaler stage outputs into the `SIM_CLK` domain and waits for ripple settling before taking a snapshot. Presents the snapshot on the channel read bus when the read strobes `RCHBT_` (low half, channel 4) and `RCHAT_` (high half, channel 3) go low. A snapshot taken for one half is held so that reading the other half returns a coherent value.

---
 rtl/a1_scaler_reader.sv | 127 ++++++++++++
 tb/tb_a1_scaler_reader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/a1_scaler_reader.sv
// Read-side consumer of the A1 scaler chain: synchronizes the ripple stage levels,
// waits for them to settle and serves a coherent two-half snapshot onto the channel bus.
module a1_scaler_reader #(
  parameter int NSTAGE     = 28,
  parameter int CHW        = 14,
  parameter int SETTLE_MAX = 4,
  parameter int HOLD_CYC   = 1024
) (
  input  logic              SIM_CLK,
  input  logic              SIM_RST,
  input  logic [NSTAGE-1:0] FS,
  input  logic              RCHBT_,
  input  logic              RCHAT_,
  output logic [CHW-1:0]    CHBUS,
  output logic              CHVALID,
  output logic              CHERR
);

  // state    | meaning
  // S_IDLE   | waiting for a strobe falling edge
  // S_SETTLE | waiting for two equal synchronized stage samples
  // S_DRIVE  | presenting the requested half while its strobe stays low
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DRIVE} state_t;

  localparam int TW = $clog2(HOLD_CYC + 1);
  localparam int CW = (SETTLE_MAX > 1) ? $clog2(SETTLE_MAX) : 1;
  localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_MAX - 1);

  state_t            r_state;
  logic [NSTAGE-1:0] r_fs_m, r_fs_s, r_fs_p;
  logic              r_b1, r_b2, r_a1, r_a2;
  logic              r_req_b, r_req_a;
  logic              r_half;
  logic [NSTAGE-1:0] r_snap;
  logic              r_held_v, r_held_half;
  logic [TW-1:0]     r_timer;
  logic [CW-1:0]     r_cnt;

  logic w_req_hi, w_hit, w_rel, w_stable;

  // Low half wins when both strobes fall together.
  assign w_req_hi = ~r_req_b;
  assign w_hit    = r_held_v && (r_timer != '0) && (r_held_half == w_req_hi);
  assign w_rel    = r_half ? r_a2 : r_b2;
  assign w_stable = (r_fs_s == r_fs_p);

  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST) begin
      r_state     <= S_IDLE;
      r_fs_m      <= '0;
      r_fs_s      <= '0;
      r_fs_p      <= '0;
      r_b1        <= 1'b1;
      r_b2        <= 1'b1;
      r_a1        <= 1'b1;
      r_a2        <= 1'b1;
      r_req_b     <= 1'b0;
      r_req_a     <= 1'b0;
      r_half      <= 1'b0;
      r_snap      <= '0;
      r_held_v    <= 1'b0;
      r_held_half <= 1'b0;
      r_timer     <= '0;
      r_cnt       <= '0;
      CHBUS       <= '0;
      CHVALID     <= 1'b0;
      CHERR       <= 1'b0;
    end else begin
      r_fs_m  <= FS;
      r_fs_s  <= r_fs_m;
      r_fs_p  <= r_fs_s;
      r_b1    <= RCHBT_;
      r_b2    <= r_b1;
      r_a1    <= RCHAT_;
      r_a2    <= r_a1;
      r_req_b <= r_b2 & ~r_b1;
      r_req_a <= r_a2 & ~r_a1;
      CHERR   <= 1'b0;
      if (r_timer != '0) r_timer <= r_timer - TW'(1);

      case (r_state)
        S_IDLE: begin
          if (r_req_b || r_req_a) begin
            r_half <= w_req_hi;
            r_cnt  <= '0;
            CHERR  <= r_req_b & r_req_a;
            if (w_hit) begin
              r_state  <= S_DRIVE;
              r_held_v <= 1'b0;
              CHVALID  <= 1'b1;
              CHBUS    <= w_req_hi ? r_snap[NSTAGE-1:CHW] : r_snap[CHW-1:0];
            end else begin
              r_state <= S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          if (w_rel) begin
            r_state <= S_IDLE;
          end else if (w_stable || (r_cnt == CNT_LAST)) begin
            // A timed-out capture is still served and held, but flagged.
            r_state     <= S_DRIVE;
            r_snap      <= r_fs_s;
            r_held_v    <= 1'b1;
            r_held_half <= ~r_half;
            r_timer     <= HOLD_LD;
            CHERR       <= ~w_stable;
            CHVALID     <= 1'b1;
            CHBUS       <= r_half ? r_fs_s[NSTAGE-1:CHW] : r_fs_s[CHW-1:0];
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DRIVE: begin
          if (w_rel) begin
            r_state <= S_IDLE;
            CHVALID <= 1'b0;
            CHBUS   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a1_scaler_reader.sv
// Scoreboard bench for a1_scaler_reader: directed reads push expected transactions,
// a negedge monitor pops and checks data, rise/fall cycles and CHERR pulses.
module tb_a1_scaler_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [27:0] fs;
  logic        b_n, a_n, b16_n, a16_n;
  logic [13:0] bus, bus16;
  logic        vld, vld16, err, err16;

  always #5 clk = ~clk;

  a1_scaler_reader dut (
    .SIM_CLK(clk), .SIM_RST(rst_n), .FS(fs), .RCHBT_(b_n), .RCHAT_(a_n),
    .CHBUS(bus), .CHVALID(vld), .CHERR(err)
  );

  a1_scaler_reader #(.HOLD_CYC(16)) dut16 (
    .SIM_CLK(clk), .SIM_RST(rst_n), .FS(fs), .RCHBT_(b16_n), .RCHAT_(a16_n),
    .CHBUS(bus16), .CHVALID(vld16), .CHERR(err16)
  );

  typedef struct {
    logic [13:0] data;
    int          rise;
    int          fall;
  } exp_t;

  exp_t q0[$];
  exp_t q16[$];
  int   eq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done = 1'b0;
  bit   fin = 1'b0;
  logic pv0 = 1'b0, pv16 = 1'b0;
  exp_t cur0, cur16;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (cyc == 2) begin
      chk("rst_vld", vld, 0);
      chk("rst_bus", bus, 0);
      chk("rst_err", err, 0);
    end
    if (cyc >= 2) begin
      if (vld && !pv0) begin
        chk("q0_nonempty", q0.size() > 0, 1);
        if (q0.size() > 0) begin
          cur0 = q0.pop_front();
          chk("rise_data", bus, cur0.data);
          chk("rise_cyc", cyc, cur0.rise);
        end
      end else if (vld) begin
        chk("hold_data", bus, cur0.data);
      end else begin
        chk("idle_bus", bus, 0);
        if (pv0) chk("fall_cyc", cyc, cur0.fall);
      end
      pv0 = vld;

      if (vld16 && !pv16) begin
        chk("q16_nonempty", q16.size() > 0, 1);
        if (q16.size() > 0) begin
          cur16 = q16.pop_front();
          chk("rise16_data", bus16, cur16.data);
          chk("rise16_cyc", cyc, cur16.rise);
        end
      end else if (vld16) begin
        chk("hold16_data", bus16, cur16.data);
      end else begin
        chk("idle16_bus", bus16, 0);
        if (pv16) chk("fall16_cyc", cyc, cur16.fall);
      end
      pv16 = vld16;

      if (err) begin
        chk("err_expected", eq.size() > 0, 1);
        if (eq.size() > 0) chk("err_cyc", cyc, eq.pop_front());
      end
      chk("err16_low", err16, 0);
    end
    if (done && !fin) begin
      chk("q0_left", q0.size(), 0);
      chk("q16_left", q16.size(), 0);
      chk("err_left", eq.size(), 0);
      fin = 1'b1;
    end
  end

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic set_strb(int sel, logic v);
    case (sel)
      0: b_n = v;
      1: a_n = v;
      2: begin b_n = v; a_n = v; end
      3: b16_n = v;
      default: a16_n = v;
    endcase
  endtask

  // Called right after a negedge; strobe goes low now, first low sample is the next edge.
  task automatic rd(int sel, int nlow, int lat, logic [13:0] d,
                    int rst_at, bit tog, bit err_exp, int err_off);
    int   k;
    exp_t e;
    k      = cyc;
    e.data = d;
    e.rise = k + 1 + lat;
    e.fall = (rst_at > 0) ? k + rst_at + 1 : k + nlow + 3;
    if (sel >= 3) q16.push_back(e);
    else q0.push_back(e);
    if (err_exp) eq.push_back(k + err_off);
    set_strb(sel, 1'b0);
    if (tog) fs[0] = ~fs[0];
    for (int j = 1; j < nlow; j++) begin
      @(negedge clk);
      if (tog) fs[0] = ~fs[0];
      if (j == rst_at) begin
        rst_n = 1'b0;
        set_strb(sel, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    @(negedge clk);
    set_strb(sel, 1'b1);
  endtask

  logic [27:0] v, w;
  int          c0;

  initial begin
    rst_n = 1'b0; fs = '0;
    b_n = 1'b1; a_n = 1'b1; b16_n = 1'b1; a16_n = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(3);

    // Low-half read: 28'h0ABC123 -> 14'h0123, latency 3
    fs = 28'h0ABC123; idle(4);
    rd(0, 5, 3, 14'h0123, 0, 0, 0, 0); idle(5);

    // Coherent pair: high half served from the held snapshot after FS changed
    fs = 28'hFFFFFFF; idle(4);
    rd(0, 4, 3, 14'h3FFF, 0, 0, 0, 0);
    fs = 28'h0000000; idle(50);
    rd(1, 4, 2, 14'h3FFF, 0, 0, 0, 0); idle(5);
    rd(1, 4, 3, 14'h0000, 0, 0, 0, 0); idle(5);

    // Settle timeout: bit 0 toggles, high half is unaffected; capture at E+6 with CHERR
    v = 28'h5555AAA; fs = v; idle(4);
    rd(1, 10, 6, v[27:14], 0, 1, 1, 7); idle(5);

    // Simultaneous strobes: hits the low half held from a fresh high read
    v = 28'h1234567; fs = v; idle(4);
    rd(1, 4, 3, v[27:14], 0, 0, 0, 0); idle(5);
    fs = 28'h7654321; idle(4);
    rd(2, 4, 2, v[13:0], 0, 0, 1, 3); idle(5);

    // Reset during DRIVE clears the bus and the hold
    v = 28'h0F0F0F0; fs = v; idle(4);
    rd(0, 8, 3, v[13:0], 5, 0, 0, 0); idle(5);
    v = 28'h0A5A5A5; fs = v; idle(4);
    rd(1, 4, 3, v[27:14], 0, 0, 0, 0); idle(5);

    // HOLD_CYC = 16: partner request seen 15 cycles after capture hits
    v = 28'h2468ACE; fs = v; idle(4);
    c0 = cyc + 4;
    rd(3, 3, 3, v[13:0], 0, 0, 0, 0);
    fs = 28'h1357BDF;
    wait_until(c0 + 13);
    rd(4, 3, 2, v[27:14], 0, 0, 0, 0); idle(5);

    // Partner request seen 20 cycles after capture: expired, fresh capture
    v = 28'h3C3C3C3; fs = v; idle(4);
    c0 = cyc + 4;
    rd(3, 3, 3, v[13:0], 0, 0, 0, 0);
    w = 28'h1E1E1E1; fs = w;
    wait_until(c0 + 18);
    rd(4, 3, 3, w[27:14], 0, 0, 0, 0); idle(10);

    done = 1'b1;
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
